// File: rtl/sha_msg_padder.sv
// SHA-256 message padder: packs a word stream into 512-bit blocks, appends
// the 0x80 marker and 64-bit bit length, and hands blocks to a hash core.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   msg_valid/msg_ready word handshake (ready only while filling)
//   msg_data/bytes/last big-endian word, valid byte count, end of message
//   core_status         hash core idle/done flag
//   first_state         strobe: first block of a message
//   next_state          strobe: subsequent block of a message
//   message_block       block to hash, word 0 in [511:480]
//   initial_state       SHA-256 IV, H0 in [31:0]
//   block_count         blocks issued for the current message
//   hash_done           pulse once the final block has been hashed
module sha_msg_padder (
    input  logic         clk,
    input  logic         reset,
    input  logic         msg_valid,
    input  logic [31:0]  msg_data,
    input  logic [2:0]   msg_bytes,
    input  logic         msg_last,
    output logic         msg_ready,
    input  logic         core_status,
    output logic         first_state,
    output logic         next_state,
    output logic [511:0] message_block,
    output logic [255:0] initial_state,
    output logic [7:0]   block_count,
    output logic         hash_done
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    localparam logic [255:0] SHA256_IV =
        256'h5be0cd19_1f83d9ab_9b05688c_510e527f_a54ff53a_3c6ef372_bb67ae85_6a09e667;

    state_e             state_q, state_d;
    logic [15:0][31:0]  blk_q, blk_d;
    logic [3:0]         wptr_q, wptr_d;
    logic [63:0]        len_q, len_d;
    logic [7:0]         cnt_q, cnt_d;
    // Word index holding (or due to hold) the 0x80 marker; 16 means the
    // marker spills into the following block.
    logic [4:0]         pw_q, pw_d;
    // Marker still has to be written at word pw_q.
    logic               p80_q, p80_d;
    // Current block is not final and a padding block follows.
    logic               more_q, more_d;
    // Current block is the last of the message.
    logic               final_q, final_d;
    // First WAIT cycle, where core_status may still show the old idle.
    logic               wfirst_q, wfirst_d;

    logic [2:0]         nbytes;
    logic [31:0]        keep_mask;
    logic [31:0]        pad_word;

    assign initial_state = SHA256_IV;
    assign message_block = blk_q;
    assign block_count   = cnt_q;

    // Byte counts 5-7 behave as a full word.
    always_comb begin
        unique case (msg_bytes)
            3'd0:    nbytes = 3'd0;
            3'd1:    nbytes = 3'd1;
            3'd2:    nbytes = 3'd2;
            3'd3:    nbytes = 3'd3;
            default: nbytes = 3'd4;
        endcase
    end

    // Valid bytes are kept; the marker lands right after them when the
    // word has room for it.
    always_comb begin
        unique case (nbytes)
            3'd0: begin
                keep_mask = 32'h0000_0000;
                pad_word  = 32'h8000_0000;
            end
            3'd1: begin
                keep_mask = 32'hff00_0000;
                pad_word  = 32'h0080_0000;
            end
            3'd2: begin
                keep_mask = 32'hffff_0000;
                pad_word  = 32'h0000_8000;
            end
            3'd3: begin
                keep_mask = 32'hffff_ff00;
                pad_word  = 32'h0000_0080;
            end
            default: begin
                keep_mask = 32'hffff_ffff;
                pad_word  = 32'h0000_0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            blk_q    <= '0;
            wptr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            pw_q     <= '0;
            p80_q    <= 1'b0;
            more_q   <= 1'b0;
            final_q  <= 1'b0;
            wfirst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            wptr_q   <= wptr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            pw_q     <= pw_d;
            p80_q    <= p80_d;
            more_q   <= more_d;
            final_q  <= final_d;
            wfirst_q <= wfirst_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        blk_d       = blk_q;
        wptr_d      = wptr_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        pw_d        = pw_q;
        p80_d       = p80_q;
        more_d      = more_q;
        final_d     = final_q;
        wfirst_d    = wfirst_q;
        msg_ready   = 1'b0;
        first_state = 1'b0;
        next_state  = 1'b0;
        hash_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = FILL;
            end

            FILL: begin
                msg_ready = 1'b1;
                // A zero-byte word without msg_last carries nothing.
                if (msg_valid && (nbytes != 3'd0 || msg_last)) begin
                    blk_d[4'd15 - wptr_q] = (msg_data & keep_mask) | pad_word;
                    len_d  = len_q + {58'd0, nbytes, 3'b000};
                    wptr_d = wptr_q + 4'd1;
                    if (msg_last) begin
                        if (nbytes == 3'd4) begin
                            pw_d  = {1'b0, wptr_q} + 5'd1;
                            p80_d = 1'b1;
                        end else begin
                            pw_d  = {1'b0, wptr_q};
                            p80_d = 1'b0;
                        end
                        more_d  = 1'b0;
                        final_d = 1'b0;
                        state_d = PAD;
                    end else if (wptr_q == 4'd15) begin
                        more_d  = 1'b0;
                        final_d = 1'b0;
                        state_d = ISSUE;
                    end
                end
            end

            PAD: begin
                state_d = ISSUE;
                if (pw_q[4]) begin
                    // Data filled the block; marker opens the next one.
                    more_d = 1'b1;
                    pw_d   = 5'd0;
                end else begin
                    if (p80_q) begin
                        blk_d[4'd15 - pw_q[3:0]] = 32'h8000_0000;
                    end
                    p80_d = 1'b0;
                    if (pw_q <= 5'd13) begin
                        blk_d[1] = len_q[63:32];
                        blk_d[0] = len_q[31:0];
                        final_d  = 1'b1;
                        more_d   = 1'b0;
                    end else begin
                        // No room for the length; it gets its own block.
                        more_d = 1'b1;
                        pw_d   = 5'd0;
                    end
                end
            end

            ISSUE: begin
                if (core_status) begin
                    if (cnt_q == 8'd0) begin
                        first_state = 1'b1;
                    end else begin
                        next_state = 1'b1;
                    end
                    cnt_d    = cnt_q + 8'd1;
                    wfirst_d = 1'b1;
                    state_d  = WAIT;
                end
            end

            WAIT: begin
                if (wfirst_q) begin
                    wfirst_d = 1'b0;
                end else if (core_status) begin
                    // Clearing here leaves zeros behind every later write.
                    blk_d = '0;
                    if (final_q) begin
                        state_d = DONE;
                    end else if (more_q) begin
                        state_d = PAD;
                    end else begin
                        wptr_d  = 4'd0;
                        state_d = FILL;
                    end
                end
            end

            DONE: begin
                hash_done = 1'b1;
                len_d     = '0;
                wptr_d    = '0;
                cnt_d     = '0;
                pw_d      = '0;
                p80_d     = 1'b0;
                more_d    = 1'b0;
                final_d   = 1'b0;
                state_d   = FILL;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sha_msg_padder.sv
// Scoreboard bench for sha_msg_padder: expected blocks are queued as
// messages are sent and a monitor checks each strobe and hash_done.
module tb_sha_msg_padder;

    logic         clk = 1'b0;
    logic         reset;
    logic         msg_valid;
    logic [31:0]  msg_data;
    logic [2:0]   msg_bytes;
    logic         msg_last;
    logic         msg_ready;
    logic         core_status;
    logic         first_state;
    logic         next_state;
    logic [511:0] message_block;
    logic [255:0] initial_state;
    logic [7:0]   block_count;
    logic         hash_done;

    localparam logic [255:0] IV =
        256'h5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667;
    localparam logic [447:0] S56 =
        "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    localparam logic [511:0] S64 =
        "0123456789abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ#$";

    int checks = 0;
    int errors = 0;

    logic [511:0] exp_blk_q[$];
    bit           exp_first_q[$];
    int           exp_cnt_q[$];
    byte unsigned msg_buf[0:127];
    logic [2:0]   full_code = 3'd4;
    bit           prev_strobe = 1'b0;
    logic [511:0] mon_blk;
    bit           mon_first;
    int           mon_cnt;

    always #5 clk = ~clk;

    sha_msg_padder dut (
        .clk           (clk),
        .reset         (reset),
        .msg_valid     (msg_valid),
        .msg_data      (msg_data),
        .msg_bytes     (msg_bytes),
        .msg_last      (msg_last),
        .msg_ready     (msg_ready),
        .core_status   (core_status),
        .first_state   (first_state),
        .next_state    (next_state),
        .message_block (message_block),
        .initial_state (initial_state),
        .block_count   (block_count),
        .hash_done     (hash_done)
    );

    task automatic check(input bit ok, input string nm,
                         input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Hash core model: goes busy after each strobe, idle 3 cycles later.
    initial begin
        core_status = 1'b1;
        forever begin
            @(negedge clk);
            if (first_state || next_state) begin
                @(posedge clk);
                #1 core_status = 1'b0;
                repeat (3) @(posedge clk);
                #1 core_status = 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (first_state || next_state) begin
            check(!(first_state && next_state), "strobe_both",
                  {first_state, next_state}, 2'b00);
            check(!prev_strobe, "strobe_repeat", prev_strobe, 0);
            if (exp_blk_q.size() == 0) begin
                check(1'b0, "unexpected_strobe", message_block, 0);
            end else begin
                mon_blk   = exp_blk_q.pop_front();
                mon_first = exp_first_q.pop_front();
                check(message_block === mon_blk, "block",
                      message_block, mon_blk);
                check(first_state === mon_first && next_state === !mon_first,
                      "strobe_kind", {first_state, next_state},
                      {mon_first, !mon_first});
            end
        end
        prev_strobe = first_state || next_state;
        if (hash_done) begin
            if (exp_cnt_q.size() == 0) begin
                check(1'b0, "unexpected_done", block_count, 0);
            end else begin
                mon_cnt = exp_cnt_q.pop_front();
                check(block_count === 8'(mon_cnt), "block_count",
                      block_count, 8'(mon_cnt));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check(msg_ready === 1'b0, {tag, "_ready"}, msg_ready, 0);
        check(first_state === 1'b0 && next_state === 1'b0, {tag, "_strobe"},
              {first_state, next_state}, 0);
        check(hash_done === 1'b0, {tag, "_done"}, hash_done, 0);
        check(message_block === '0, {tag, "_block"}, message_block, 0);
        check(block_count === 8'd0, {tag, "_count"}, block_count, 0);
        check(initial_state === IV, {tag, "_iv"}, initial_state, IV);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] b,
                             input logic l);
        int t;
        msg_valid = 1'b1;
        msg_data  = d;
        msg_bytes = b;
        msg_last  = l;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!msg_ready && t < 300);
        if (!msg_ready) check(1'b0, "ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        msg_data  = 32'h0;
        msg_bytes = 3'd0;
        msg_last  = 1'b0;
    endtask

    task automatic load_buf(input logic [511:0] s, input int len);
        for (int i = 0; i < len; i++) msg_buf[i] = s[511-8*i -: 8];
    endtask

    // Unused byte lanes carry 0xAA so masking is exercised.
    task automatic send_msg(input int len);
        int n;
        logic [31:0] w;
        if (len == 0) begin
            send_word(32'hAAAA_AAAA, 3'd0, 1'b1);
            return;
        end
        for (int i = 0; i < len; i += 4) begin
            n = (len - i > 4) ? 4 : len - i;
            w = 32'hAAAA_AAAA;
            for (int k = 0; k < n; k++) w[31-8*k -: 8] = msg_buf[i+k];
            send_word(w, (n == 4) ? full_code : 3'(n), (i + 4 >= len));
        end
    endtask

    task automatic push_blk(input logic [511:0] b, input bit first);
        exp_blk_q.push_back(b);
        exp_first_q.push_back(first);
    endtask

    // Reference SHA-256 padding of msg_buf[0:len-1].
    task automatic push_model(input int len);
        byte unsigned p[0:191];
        int nb;
        logic [63:0] bits;
        logic [511:0] b;
        for (int i = 0; i < 192; i++) p[i] = 8'h00;
        for (int i = 0; i < len; i++) p[i] = msg_buf[i];
        p[len] = 8'h80;
        nb = (len + 8) / 64 + 1;
        bits = 64'(len) * 64'd8;
        for (int k = 0; k < 8; k++) p[nb*64-8+k] = bits[63-8*k -: 8];
        for (int bi = 0; bi < nb; bi++) begin
            for (int j = 0; j < 64; j++) b[511-8*j -: 8] = p[bi*64+j];
            push_blk(b, bi == 0);
        end
        exp_cnt_q.push_back(nb);
    endtask

    task automatic send_abc();
        push_blk({32'h61626380, 416'd0, 64'h18}, 1'b1);
        exp_cnt_q.push_back(1);
        send_word(32'h616263AA, 3'd3, 1'b1);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_blk_q.size() != 0 || exp_cnt_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(t < 3000, "drain_timeout", exp_blk_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    logic [511:0] snap;

    initial begin
        reset     = 1'b1;
        msg_valid = 1'b0;
        msg_data  = 32'h0;
        msg_bytes = 3'd0;
        msg_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1 reset = 1'b0;

        // "abc"
        send_abc();

        // empty message
        push_blk({32'h80000000, 480'd0}, 1'b1);
        exp_cnt_q.push_back(1);
        send_msg(0);

        // 56 bytes: length spills into a second block
        load_buf({S56, 64'd0}, 56);
        push_blk({S56, 32'h80000000, 32'h0}, 1'b1);
        push_blk({448'd0, 64'h1C0}, 1'b0);
        exp_cnt_q.push_back(2);
        send_msg(56);

        // 64 bytes: marker starts the second block
        load_buf(S64, 64);
        push_blk(S64, 1'b1);
        push_blk({32'h80000000, 416'd0, 64'h200}, 1'b0);
        exp_cnt_q.push_back(2);
        send_msg(64);

        // Assorted lengths around the block boundaries
        foreach (msg_buf[i]) msg_buf[i] = 8'(i * 7 + 3);
        push_model(1);   send_msg(1);
        push_model(4);   send_msg(4);
        push_model(5);   send_msg(5);
        push_model(55);  send_msg(55);
        push_model(57);  send_msg(57);
        full_code = 3'd7;
        push_model(60);  send_msg(60);
        full_code = 3'd4;
        push_model(63);  send_msg(63);
        push_model(119); send_msg(119);
        push_model(128); send_msg(128);
        wait_drain();

        // Core held busy while a block sits in ISSUE
        core_status = 1'b0;
        send_abc();
        @(posedge clk);
        #1;
        snap = message_block;
        check(snap === {32'h61626380, 416'd0, 64'h18}, "issue_block",
              snap, {32'h61626380, 416'd0, 64'h18});
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check(!first_state && !next_state, "hold_strobe",
                  {first_state, next_state}, 0);
            check(message_block === snap, "hold_block", message_block, snap);
            check(msg_ready === 1'b0, "hold_ready", msg_ready, 0);
        end
        @(posedge clk);
        #1 core_status = 1'b1;
        @(negedge clk);
        check(first_state === 1'b1, "strobe_on_rise", first_state, 1);
        wait_drain();

        // Reset after 7 words of a message
        foreach (msg_buf[i]) msg_buf[i] = 8'(i + 8'h41);
        for (int i = 0; i < 7; i++)
            send_word({msg_buf[4*i], msg_buf[4*i+1], msg_buf[4*i+2],
                       msg_buf[4*i+3]}, 3'd4, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check(!first_state && !next_state, "rst_release_strobe",
              {first_state, next_state}, 0);
        @(posedge clk);
        #1;
        send_abc();
        wait_drain();

        check(exp_blk_q.size() == 0, "left_blocks", exp_blk_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha_msg_padder.md
SHA_MSG_PADDER -- requirements
Module: sha_msg_padder

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; all state changes on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 msg_valid  input  1  msg_data/msg_bytes/msg_last are valid this cycle.
REQ-005 msg_data  input  32  message word, big-endian; valid bytes left-justified in [31:24], [23:16], ...
REQ-006 msg_bytes  input  3  valid bytes in msg_data:
  - 1-4 normally.
  - 0 legal only with msg_last.
  - 5-7 treated as 4.
REQ-007 msg_last  input  1  marks the final word of the message.
REQ-008 msg_ready  output  1  padder accepts a word this cycle when msg_valid=1.
REQ-009 core_status  input  1  downstream hash core ready flag (1 = idle/done).
REQ-010 first_state  output  1  one-cycle strobe: first block of a message.
REQ-011 next_state  output  1  one-cycle strobe: subsequent block.
REQ-012 message_block  output  512  block to hash; word 0 in [511:480], word 15 in [31:0].
REQ-013 initial_state  output  256  SHA-256 IV, constant:
  - 0x5be0cd191f83d9ab9b05688c510e527fa54ff53a3c6ef372bb67ae856a09e667.
  - H0 in [31:0], H7 in [255:224].
REQ-014 block_count  output  8  blocks issued for the current message; wraps at 255.
REQ-015 hash_done  output  1  one-cycle pulse when the final block of a message has completed in the core.

Function
REQ-016 The FSM SHALL have states IDLE, FILL, PAD, ISSUE, WAIT, DONE.
REQ-017 IDLE -> FILL on the first cycle after reset deassertion; block_count clears on entry to FILL from DONE.
REQ-018 FILL behaviour:
  - msg_ready=1.
  - Each accepted word is written at word index wptr (0-15); wptr increments.
  - The 64-bit bit-length counter adds 8*msg_bytes, modulo 2^64.
REQ-019 FILL, accepted word with msg_last=0 and wptr=15 -> ISSUE with the block full (unpadded).
REQ-020 FILL, accepted word with msg_last=1 -> PAD. The 0x80 byte is placed directly after the last valid byte:
  - inside the same word when msg_bytes<4;
  - at [31:24] of the next word when msg_bytes=4.
  - All following bytes are zero.
REQ-021 PAD: if the 0x80 byte lands at byte offset <=55 of the block, the bit length is written to [63:0] and the block goes to ISSUE as final; otherwise the block goes to ISSUE as non-final and a second all-zero block carrying only the length in [63:0] follows as final.
REQ-022 If the 0x80 byte falls at offset 64 (message length a multiple of 64 bytes), the final block SHALL be 0x80000000, zeros, then the length.
REQ-023 ISSUE behaviour:
  - Waits for core_status=1, then pulses exactly one strobe for one cycle.
  - The strobe is first_state if block_count=0, else next_state.
  - block_count increments; the FSM goes to WAIT.
REQ-024 message_block SHALL remain stable from ISSUE entry until the WAIT exit.
REQ-025 WAIT behaviour:
  - Ignores core_status in the first cycle after the strobe, then waits for core_status=1.
  - Then goes to PAD (pending length-only block), FILL (wptr cleared, message not finished) or DONE (final block).
REQ-026 DONE: pulse hash_done for one cycle, clear the length counter and wptr, go to FILL.
REQ-027 msg_ready SHALL be 0 in every state except FILL; words offered while msg_ready=0 are neither consumed nor lost.
REQ-028 first_state and next_state SHALL never be high in the same cycle, and never for more than one consecutive cycle.

Reset
REQ-029 Reset SHALL force, at any time including mid-message or mid-ISSUE/WAIT:
  - state=IDLE;
  - msg_ready, first_state, next_state, hash_done = 0;
  - message_block, block_count, wptr, length counter = 0.
  - initial_state keeps its constant value.
REQ-030 No strobe SHALL be emitted in the cycle reset deasserts; a partially buffered message is discarded.

Verification
REQ-031 "abc": one word 0x61626300, msg_bytes=3, msg_last=1 -> one first_state pulse; message_block = 0x61626380, 14 zero words, 0x00000018; hash_done after core_status returns high.
REQ-032 Empty message (msg_bytes=0, msg_last=1) -> one block: 0x80000000, zeros, length 0.
REQ-033 56-byte message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Two blocks. Block 1 is the data followed by 0x80000000, 0x00000000, issued with first_state.
  - Block 2 is all zeros with [63:0]=0x1C0, issued with next_state.
  - block_count=2.
REQ-034 64-byte message -> block 1 is the data (first_state); block 2 = 0x80000000, zeros, [63:0]=0x200 (next_state).
REQ-035 Hold core_status=0 for 20 cycles in ISSUE -> no strobe, message_block unchanged, msg_ready=0; strobe issued on the cycle core_status rises.
REQ-036 Assert reset after 7 words of a message -> all outputs 0. A new "abc" message then yields REQ-031 exactly (length 0x18, not accumulated).
